// File: rtl/seq_shift_detector.sv
// Serial shift-register pattern detector.
// A DEPTH-bit history register captures x_in on each shift_en cycle. The word
// the history would hold after this shift (the candidate) is compared against a
// loadable pattern register. The result is the Mealy output 'match'.
// A fill counter blocks matches until the history holds DEPTH real samples.
// In non-overlapping mode, a guard counter blocks matches for DEPTH-1 shifts
// after each accepted match.
module seq_shift_detector #(
    parameter int                 DEPTH         = 3,
    parameter logic [DEPTH-1:0]   RESET_PATTERN = DEPTH'('b010),
    parameter logic [DEPTH-1:0]   PATTERN_RESET = DEPTH'('b101),
    parameter int                 CNT_W         = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              x_in,
    input  logic              shift_en,
    input  logic              clr,
    input  logic              nonoverlap,
    input  logic              pattern_load,
    input  logic [DEPTH-1:0]  pattern_in,
    output logic              y_out,
    output logic [DEPTH-1:0]  history,
    output logic              match,
    output logic [CNT_W-1:0]  match_count,
    output logic              count_sat
);

    // The fill and guard counters never exceed DEPTH-1.
    localparam int             FW       = $clog2(DEPTH);
    localparam logic [FW-1:0]  FILL_MAX = FW'(DEPTH - 1);

    logic [DEPTH-1:0]  history_q, history_d;
    logic [DEPTH-1:0]  pattern_q, pattern_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic [FW-1:0]     guard_q, guard_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  candidate;

    assign candidate   = {history_q[DEPTH-2:0], x_in};
    assign y_out       = history_q[DEPTH-1];
    assign history     = history_q;
    assign match_count = count_q;
    assign count_sat   = &count_q;

    // Match decision: compared against the current pattern register, so a same-cycle load is not seen yet.
    always_comb begin
        match = shift_en && !clr && (candidate == pattern_q)
                && (fill_q == FILL_MAX) && (guard_q == '0);
    end

    // Next-state for history, pattern, fill, guard and counter; clr overrides shifting.
    always_comb begin
        history_d = history_q;
        pattern_d = pattern_q;
        fill_d    = fill_q;
        guard_d   = guard_q;
        count_d   = count_q;

        if (pattern_load) begin
            pattern_d = pattern_in;
        end

        if (clr) begin
            history_d = RESET_PATTERN;
            fill_d    = '0;
            guard_d   = '0;
            count_d   = '0;
        end else if (shift_en) begin
            history_d = candidate;
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FW'(1);
            end
            if (match && nonoverlap) begin
                guard_d = FILL_MAX;
            end else if (guard_q != '0) begin
                guard_d = guard_q - FW'(1);
            end
            if (match && !count_sat) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            history_q <= RESET_PATTERN;
            pattern_q <= PATTERN_RESET;
            fill_q    <= '0;
            guard_q   <= '0;
            count_q   <= '0;
        end else begin
            history_q <= history_d;
            pattern_q <= pattern_d;
            fill_q    <= fill_d;
            guard_q   <= guard_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: doc/seq_shift_detector.md
SEQ_SHIFT_DETECTOR -- requirements
Module: seq_shift_detector

Interface
REQ-001 SHALL have parameter DEPTH, default 3, history length in bits (legal range 2..16).
REQ-002 SHALL have parameter RESET_PATTERN, default 'b010 (DEPTH bits), history value after reset or clear.
REQ-003 SHALL have parameter PATTERN_RESET, default 'b101 (DEPTH bits), match-pattern register value after reset.
REQ-004 SHALL have parameter CNT_W, default 8, match counter width.
REQ-005 SHALL have port clock  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port x_in  input  1  serial data bit.
REQ-008 SHALL have port shift_en  input  1  shift x_in into history this cycle.
REQ-009 SHALL have port clr  input  1  synchronous clear of history, fill, guard and counter.
REQ-010 SHALL have port nonoverlap  input  1  1 = non-overlapping detection, 0 = overlapping.
REQ-011 SHALL have port pattern_load  input  1  load pattern_in into the pattern register.
REQ-012 SHALL have port pattern_in  input  DEPTH  new match pattern.
REQ-013 SHALL have port y_out  output  1  delayed serial output, history[DEPTH-1] (registered).
REQ-014 SHALL have port history  output  DEPTH  current history register.
REQ-015 SHALL have port match  output  1  Mealy match indication (combinational).
REQ-016 SHALL have port match_count  output  CNT_W  registered count of accepted matches.
REQ-017 SHALL have port count_sat  output  1  high while match_count is all ones.

Function
REQ-018 On a clock edge with shift_en=1 and clr=0, history SHALL become {history[DEPTH-2:0], x_in}; otherwise it SHALL hold.
REQ-019 y_out SHALL equal history[DEPTH-1], giving a DEPTH-cycle delay of x_in measured in shift_en cycles.
REQ-020 The candidate word SHALL be {history[DEPTH-2:0], x_in}.
REQ-021 match SHALL be 1 iff shift_en=1, clr=0, candidate==pattern register, fill==DEPTH-1 and guard==0.
REQ-022 The fill counter SHALL increment on each shift_en edge and saturate at DEPTH-1; it SHALL reset to 0 on reset and clr.
REQ-023 On an edge where match=1 and nonoverlap=1, guard SHALL load DEPTH-1; otherwise on each shift_en edge a nonzero guard SHALL decrement by 1.
REQ-024 With nonoverlap=0, guard SHALL remain 0.
REQ-025 match_count SHALL increment by 1 on each edge where match=1 and SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-026 pattern_load SHALL update the pattern register at the clock edge; match in that same cycle SHALL use the old pattern.
REQ-027 clr SHALL have priority over shift_en: history to RESET_PATTERN, fill, guard and match_count to 0; pattern register retained; match forced to 0 that cycle.
REQ-028 Changing nonoverlap mid-stream SHALL take effect from the next match decision; an active guard SHALL continue to count down.
REQ-029 shift_en=0 SHALL freeze history, fill, guard and match_count.

Reset
REQ-030 reset low SHALL asynchronously set history=RESET_PATTERN, pattern=PATTERN_RESET, fill=0, guard=0, match_count=0.
REQ-031 During reset, y_out SHALL equal RESET_PATTERN[DEPTH-1] (0 at defaults), match=0, count_sat=0.
REQ-032 Reset asserted mid-stream SHALL discard all partial history and guard state with no match counted.

Verification
REQ-033 Defaults, reset, shift x=1,1,0 -> history 101,011,110; y_out 1,0,1.
REQ-034 Defaults, overlapping, shift x=1,0,1,0,1 -> shift1 candidate 101 suppressed by fill; match on shifts 3 and 5; match_count=2.
REQ-035 Same stimulus with nonoverlap=1, then x=0,1 -> match on shifts 3 and 7 only; match_count=2.
REQ-036 pattern_load with pattern_in=011 in the same cycle as a candidate 101 shift -> match=1 that cycle; later candidate 011 matches.
REQ-037 CNT_W=2, overlapping pattern 111, shift 1 six times -> match_count saturates at 3, count_sat=1; clr -> history 010, match_count 0.
REQ-038 Reset pulsed low between shifts 2 and 3 of the REQ-034 stream -> history 010, no match on next shift, match_count 0.
